// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display stage.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam int DIGITS = 3;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] seg_code(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

  // One double-dabble step: add-3 on BCD nibbles >= 5, then shift.
  function automatic logic [19:0] dd_step(
    input logic [19:0] r
  );
    logic [19:0] a;
    a = r;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[8+4*i +: 4] >= 4'd5)
        a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/calc_display_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter.
// One shift-add iteration per clock, done pulses after the result lands.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state;
  logic [19:0] sr;
  logic [2:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= {12'd0, bin};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= dd_step(sr);
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7)
            state <= DONE;
        end
        DONE: begin
          bcd   <= sr[19:8];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/calc_display.sv
// Calculator result display: change detect, BCD convert,
// and a multiplexed active-low 3-digit seven-segment scan.
module calc_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK       = 1'b1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIn,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RF_LAST =
    CW'(REFRESH_DIV - 1);

  logic [7:0]    shadow;
  logic          start;
  logic          done;
  logic [11:0]   bcd;
  logic [3:0]    dig_h, dig_t, dig_o;
  logic [CW-1:0] rf_cnt;
  logic [1:0]    sel;

  // The converter is only listening while idle, so a change
  // seen mid-conversion is picked up on the next idle edge.
  assign start = !busy && (dataIn != shadow);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst),
    .start (start),
    .bin   (dataIn),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      dig_h  <= '0;
      dig_t  <= '0;
      dig_o  <= '0;
    end else begin
      if (start)
        shadow <= dataIn;
      if (done) begin
        dig_h <= bcd[11:8];
        dig_t <= bcd[7:4];
        dig_o <= bcd[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_cnt <= '0;
      sel    <= '0;
    end else if (rf_cnt == RF_LAST) begin
      rf_cnt <= '0;
      sel    <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end else begin
      rf_cnt <= rf_cnt + CW'(1);
    end
  end

  logic       hide_h, hide_t;
  logic       hide;
  logic [3:0] digit;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;

  assign hide_h = BLANK && (dig_h == 4'd0);
  assign hide_t = hide_h && (dig_t == 4'd0);

  always_comb begin
    digit   = '0;
    hide    = 1'b1;
    an_nxt  = 4'b1111;
    seg_nxt = SEG_OFF;
    unique case (1'b1)
      (sel == 2'd0): begin
        digit  = dig_o;
        hide   = 1'b0;
        an_nxt = 4'b1110;
      end
      (sel == 2'd1): begin
        digit  = dig_t;
        hide   = hide_t;
        an_nxt = 4'b1101;
      end
      (sel == 2'd2): begin
        digit  = dig_h;
        hide   = hide_h;
        an_nxt = 4'b1011;
      end
      default: begin
        hide = 1'b1;
      end
    endcase
    if (hide)
      an_nxt = 4'b1111;
    else
      seg_nxt = seg_code(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: conversion latency,
// busy, blanking and scan order on two parameter sets.
module tb_calc_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataIn;
  logic [6:0] seg1, seg0;
  logic [3:0] an1, an0;
  logic       busy1, busy0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  calc_display #(.REFRESH_DIV(4), .BLANK(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .dataIn (dataIn),
    .seg    (seg1),
    .an     (an1),
    .busy   (busy1)
  );

  calc_display #(.REFRESH_DIV(4), .BLANK(1'b0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .dataIn (dataIn),
    .seg    (seg0),
    .an     (an0),
    .busy   (busy0)
  );

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [10:0] exp_out(
    input int s, input int h, input int t,
    input int o, input bit b
  );
    int d;
    bit hide;
    logic [3:0] a;
    d = (s == 0) ? o : (s == 1) ? t : h;
    hide = b && ((s == 2 && h == 0) ||
                 (s == 1 && h == 0 && t == 0));
    a = (s == 0) ? 4'b1110 :
        (s == 1) ? 4'b1101 : 4'b1011;
    if (hide) return {4'b1111, 7'b1111111};
    return {a, seg_of(d)};
  endfunction

  task automatic digs(
    input string tag, input int h,
    input int t, input int o
  );
    chk({tag, ".h"}, 32'(dut.dig_h), h);
    chk({tag, ".t"}, 32'(dut.dig_t), t);
    chk({tag, ".o"}, 32'(dut.dig_o), o);
  endtask

  task automatic scan(
    input string tag, input int h, input int t,
    input int o, input int n
  );
    logic [10:0] e1, e0;
    int s;
    for (int i = 0; i < n; i++) begin
      tick(1);
      s  = ((cyc - 1) / 4) % 3;
      e1 = exp_out(s, h, t, o, 1'b1);
      e0 = exp_out(s, h, t, o, 1'b0);
      chk({tag, ".an1"},  32'(an1),  32'(e1[10:7]));
      chk({tag, ".seg1"}, 32'(seg1), 32'(e1[6:0]));
      chk({tag, ".an0"},  32'(an0),  32'(e0[10:7]));
      chk({tag, ".seg0"}, 32'(seg0), 32'(e0[6:0]));
    end
  endtask

  initial begin
    rst = 1'b0;
    dataIn = 8'd0;
    tick(3);
    chk("rst.an",   32'(an1),   32'hF);
    chk("rst.seg",  32'(seg1),  32'h7F);
    chk("rst.busy", 32'(busy1), 0);
    chk("rst.an0",  32'(an0),   32'hF);

    // 1: idle at zero
    rst = 1'b1;
    tick(1);
    chk("t1.busy", 32'(busy1), 0);
    scan("t1", 0, 0, 0, 12);
    chk("t1.busy2", 32'(busy1), 0);

    // 2: 255, latency and busy
    dataIn = 8'd255;
    tick(1);
    tick(1);
    chk("t2.busy1", 32'(busy1), 1);
    tick(7);
    chk("t2.busy8", 32'(busy1), 1);
    tick(1);
    digs("t2.e9", 0, 0, 0);
    tick(1);
    digs("t2.e10", 2, 5, 5);
    chk("t2.busy10", 32'(busy1), 0);
    scan("t2", 2, 5, 5, 12);

    // 3: 7 with leading zeros
    dataIn = 8'd7;
    tick(11);
    digs("t3", 0, 0, 7);
    scan("t3", 0, 0, 7, 12);

    // 4: change during conversion
    dataIn = 8'd100;
    tick(1);
    tick(3);
    dataIn = 8'd42;
    tick(6);
    digs("t4.e9", 0, 0, 7);
    tick(1);
    digs("t4.e10", 1, 0, 0);
    tick(9);
    digs("t4.e19", 1, 0, 0);
    tick(1);
    digs("t4.e20", 0, 4, 2);
    scan("t4", 0, 4, 2, 12);

    // 5: reset mid-conversion
    dataIn = 8'd200;
    tick(1);
    tick(3);
    rst = 1'b0;
    #1;
    chk("t5.an",   32'(an1),   32'hF);
    chk("t5.seg",  32'(seg1),  32'h7F);
    chk("t5.busy", 32'(busy1), 0);
    chk("t5.shad", 32'(dut.shadow), 0);
    digs("t5.rst", 0, 0, 0);
    tick(2);
    rst = 1'b1;
    tick(10);
    digs("t5.k10", 0, 0, 0);
    tick(1);
    digs("t5.k11", 2, 0, 0);
    scan("t5", 2, 0, 0, 12);

    // 6: no-blank instance, scan timing
    dataIn = 8'd5;
    tick(11);
    chk("t6.o", 32'(dut0.dig_o), 5);
    chk("t6.h", 32'(dut0.dig_h), 0);
    scan("t6", 0, 0, 5, 24);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
Downstream output stage for the lab calculator. Consumes the calculator's 8-bit result bus and converts it to decimal with a sequential double-dabble converter. Drives a multiplexed, active-low 4-digit seven-segment display showing the value 0..255 on three digits. Sits between the calculator datapath and the board display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays selected (minimum 2).
BLANK, 1, 1 = suppress leading zeros; 0 = always show three digits.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
dataIn  input  8  unsigned value to display (calculator result).
seg  output  7  segment drive, active-low; seg[0]=a … seg[6]=g.
an  output  4  digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3] always 1.
busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset, asynchronous while rst=0:
  - state=IDLE, shadow=0, hundreds/tens/ones=0, refresh counter=0, digit select=0.
  - Outputs: an=4'b1111, seg=7'b1111111, busy=0.
- Reset release: first edge after rst rises, outputs resume from digit select 0.
- FSM states:
  - IDLE: every edge, compare dataIn to shadow. If they differ:
    - shadow<=dataIn.
    - Shift register {bcd[11:0], bin[7:0]} <= {12'd0, dataIn}.
    - Iteration counter<=0; go to CONV.
  - CONV: one double-dabble iteration per edge.
    - Each BCD nibble >=5 gets +3, then the 20-bit register shifts left by 1.
    - After the 8th iteration, go to DONE.
  - DONE: hundreds/tens/ones <= bcd[11:8]/bcd[7:4]/bcd[3:0], updated atomically; go to IDLE.
- Latency: display digit registers update on the 10th rising edge after the edge that detected the mismatch (1 detect + 8 CONV + 1 DONE).
- busy: 1 in CONV and DONE, 0 in IDLE. Registered, so it is high from the edge after detection.
- Changes on dataIn during CONV/DONE are ignored. On return to IDLE the mismatch is seen again and a new conversion starts. The last stable value is always displayed eventually.
- Refresh:
  - Counter counts 0..REFRESH_DIV-1 continuously, independent of FSM state.
  - At the terminal count it wraps to 0 and digit select advances 0→1→2→0.
- Outputs are registered from digit select and the digit registers, so they lag select by one edge.
- Anode drive:
  - Selected digit's anode is 0, others 1; an[3]=1 always.
  - With BLANK=1: hundreds is blanked when it is 0; tens is blanked when hundreds=0 and tens=0; ones is never blanked.
  - A blanked digit drives its anode 1 and seg=7'b1111111.
- Segment codes (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other nibble = 1111111 (unreachable).
- Reset mid-conversion: the FSM aborts immediately and shadow returns to 0. A subsequent nonzero dataIn then triggers a fresh conversion.
- Width rules:
  - Max input 255, so the hundreds nibble is at most 2. BCD arithmetic is 4-bit per nibble with no overflow.
  - Counter width is sized to hold REFRESH_DIV-1.

Decomposition:
- Shared package calc_pkg holds:
  - FSM state encodings (IDLE, CONV, DONE).
  - The ten segment-code constants and SEG_OFF=7'b1111111.
  - DIGITS=3.
- One natural sub-module: bin2bcd_seq. It contains the IDLE/CONV/DONE FSM and shift register. Its interface is start, bin[7:0], busy, done pulse, and bcd[11:0].
- The top level holds shadow/compare, the refresh counter, the anode/segment mux and blanking.

Test Plan:
1. Reset held then released with dataIn=0 → no conversion (busy stays 0); BLANK=1 shows only the ones digit, an=1110, seg=1000000; tens/hundreds slots give an=1111.
2. dataIn=255 one edge after reset release → busy high from the next edge; digits become 2/5/5 exactly 10 edges after detection. REFRESH_DIV=4 scan gives an 1110/1101/1011 with seg 0010010/0010010/0100100.
3. dataIn=7, BLANK=1 → digits 0/0/7; hundreds and tens slots blanked (an=1111); ones slot shows an=1110, seg=1111000.
4. dataIn=100, then changed to 42 three edges later → display shows 1/0/0 at +10 edges. A second conversion starts on the following IDLE edge and shows 42 (hundreds blanked) 10 edges later.
5. rst asserted during CONV of dataIn=200 → outputs go all-off immediately. After release with dataIn still 200, a full conversion runs and shows 2/0/0.
6. REFRESH_DIV=4, BLANK=0, dataIn=5 → each anode is held exactly 4 cycles in order ones, tens, hundreds, wrapping. Display reads 0/0/5 with leading zeros lit.
